// File: rtl/fp_subdiv_to_fixed.sv
// -----------------------------------------------------------------------------
// fp_subdiv_to_fixed
//
// Converts an IEEE-754 single-precision operand x into the CORDIC angle
// z = (x - 128) / 128, delivered as signed Q1.20 (21 bits, LSB = 2^-20).
// The mantissa alignment is done iteratively, one bit position per enabled
// cycle, so the stage is small but its latency depends on the exponent.
//
// Ports
//   clock   : sole clock, rising edge
//   aclr    : asynchronous active-low reset
//   clk_en  : when low, every register (state, counter, outputs) holds
//   start   : request, accepted only in IDLE or DONE while clk_en is high
//   dataa   : FP32 operand, captured on the accepting edge
//   result  : signed Q1.20 angle, held until the next result is written
//   done    : high for every cycle spent in DONE (drives the core's start)
//   busy    : high in UNPACK, ALIGN and SUB
// -----------------------------------------------------------------------------
module fp_subdiv_to_fixed (
  input  logic        clock,
  input  logic        aclr,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic [20:0] result,
  output logic        done,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_ALIGN  = 3'd2,
    S_SUB    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_x;       // latched operand
  logic [28:0] r_acc;     // Q8.20 unsigned accumulator, converges to x*2^20
  logic [4:0]  r_cnt;     // remaining alignment shifts
  logic        r_left;    // alignment direction: 1 = left, 0 = right
  logic [20:0] r_result;
  logic        r_done;
  logic        r_busy;

  // Field decode of the latched operand.
  logic        w_sign;
  logic [7:0]  w_exp;
  logic [22:0] w_frac;
  assign w_sign = r_x[31];
  assign w_exp  = r_x[30:23];
  assign w_frac = r_x[22:0];

  // Special-case classification, highest priority first.
  logic w_is_nan;
  logic w_is_neg_or_zero;
  logic w_is_big;
  logic w_is_tiny;
  assign w_is_nan         = (w_exp == 8'd255) && (w_frac != 23'd0);
  assign w_is_neg_or_zero = w_sign || (w_exp == 8'd0);
  assign w_is_big         = (w_exp >= 8'd135);
  assign w_is_tiny        = (w_exp < 8'd106);

  // Alignment amount: the accumulator holds M, and x*2^20 = M * 2^(e-130).
  logic       w_left;
  logic [7:0] w_exp_dist;
  logic [4:0] w_shift_n;
  assign w_left = (w_exp > 8'd130);

  // Distance of the exponent from 130; only values 0..24 reach the datapath.
  always_comb begin
    w_exp_dist = 8'd0;
    if (w_left) begin
      w_exp_dist = w_exp - 8'd130;
    end else begin
      w_exp_dist = 8'd130 - w_exp;
    end
  end
  assign w_shift_n = w_exp_dist[4:0];

  // Special-case result mux, applied in priority order.
  logic        w_special;
  logic [20:0] w_special_res;

  // Selects whether the operand bypasses the datapath and what it produces.
  always_comb begin
    w_special     = 1'b0;
    w_special_res = 21'h000000;
    if (w_is_nan) begin
      w_special     = 1'b1;
      w_special_res = 21'h000000;
    end else if (w_is_neg_or_zero) begin
      w_special     = 1'b1;
      w_special_res = 21'h100000;
    end else if (w_is_big) begin
      w_special     = 1'b1;
      w_special_res = 21'h0FFFFF;
    end else if (w_is_tiny) begin
      w_special     = 1'b1;
      w_special_res = 21'h100000;
    end else begin
      w_special     = 1'b0;
      w_special_res = 21'h000000;
    end
  end

  // D = A - 2^27 (i.e. x*2^20 - 128*2^20); result is D >>> 7. For every
  // reachable A the quotient fits in 21 signed bits, so D[27:7] is exactly
  // the arithmetic-shift result and the bits above it are sign copies.
  logic signed [29:0] w_diff;
  assign w_diff = $signed({1'b0, r_acc}) - 30'sd134217728;

  // Bits that carry no information for the output are collected here.
  logic w_unused_bits;
  assign w_unused_bits = ^{w_diff[29:28], w_diff[6:0], w_exp_dist[7:5]};

  // Control FSM and datapath registers, including the registered outputs.
  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      r_state  <= S_IDLE;
      r_x      <= 32'd0;
      r_acc    <= 29'd0;
      r_cnt    <= 5'd0;
      r_left   <= 1'b0;
      r_result <= 21'd0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else if (clk_en) begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_x     <= dataa;
            r_state <= S_UNPACK;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
          end
        end

        S_UNPACK: begin
          if (w_special) begin
            r_result <= w_special_res;
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
          end else begin
            r_acc  <= {5'd0, 1'b1, w_frac};
            r_cnt  <= w_shift_n;
            r_left <= w_left;
            if (w_shift_n == 5'd0) begin
              r_state <= S_SUB;
            end else begin
              r_state <= S_ALIGN;
            end
          end
        end

        S_ALIGN: begin
          // Left shifts never exceed 4, so bit 28 cannot be lost.
          if (r_left) begin
            r_acc <= {r_acc[27:0], 1'b0};
          end else begin
            r_acc <= {1'b0, r_acc[28:1]};
          end
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt <= 5'd1) begin
            r_state <= S_SUB;
          end else begin
            r_state <= S_ALIGN;
          end
        end

        S_SUB: begin
          r_result <= w_diff[27:7];
          r_state  <= S_DONE;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign result = r_result;
  assign done   = r_done;
  assign busy   = r_busy;

endmodule

// File: tb/tb_fp_subdiv_to_fixed.sv
// -----------------------------------------------------------------------------
// tb_fp_subdiv_to_fixed
//
// Self-checking bench for fp_subdiv_to_fixed: a table of directed vectors,
// hand-written multi-cycle sequences (start ignored while busy, back-to-back,
// clk_en stall, aclr mid-operation) and a randomized exponent sweep checked
// against a real-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_fp_subdiv_to_fixed;

  logic        clock;
  logic        aclr;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [20:0] result;
  logic        done;
  logic        busy;

  int n_cmp;
  int n_err;

  fp_subdiv_to_fixed dut (
    .clock  (clock),
    .aclr   (aclr),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .result (result),
    .done   (done),
    .busy   (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] x;
    logic [20:0] res;
    int          lat;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: z = floor((floor(x*2^20) - 2^27) / 128), computed in reals.
  function automatic void model(input logic [31:0] x, output logic [20:0] r, output int lat);
    int          e;
    logic [23:0] m;
    real         xr;
    real         d;
    real         q;
    int          qi;
    e = int'(x[30:23]);
    m = {1'b1, x[22:0]};
    lat = 2;
    r = 21'h000000;
    if (e == 255 && x[22:0] != 23'd0) begin
      r = 21'h000000;
    end else if (x[31] || e == 0) begin
      r = 21'h100000;
    end else if (e >= 135) begin
      r = 21'h0FFFFF;
    end else if (e < 106) begin
      r = 21'h100000;
    end else begin
      xr = real'(m) * (2.0 ** (e - 150));
      d  = $floor(xr * 1048576.0) - 134217728.0;
      q  = $floor(d / 128.0);
      qi = $rtoi(q);
      r  = qi[20:0];
      lat = ((e > 130) ? (e - 130) : (130 - e)) + 3;
    end
  endfunction

  // Runs one operation. Latency counts the accepting edge as cycle 1.
  // en_off_at: cycle at which clk_en drops for 5 cycles (0 = never).
  // pulse_at : cycle at which start is pulsed with other data (0 = never).
  task automatic do_op(input logic [31:0] x, input int en_off_at, input int pulse_at,
                       output logic [20:0] res, output int lat, output logic [127:0] btrace);
    btrace = '0;
    @(negedge clock);
    start = 1'b1;
    dataa = x;
    @(posedge clock);
    lat = 1;
    #1;
    start = 1'b0;
    dataa = $urandom;
    while (done !== 1'b1 && lat < 80) begin
      btrace[lat] = busy;
      clk_en = !(en_off_at > 0 && lat >= en_off_at && lat < en_off_at + 5);
      if (pulse_at == lat) begin
        start = 1'b1;
        dataa = 32'h3F800000;
      end else begin
        start = 1'b0;
      end
      @(posedge clock);
      lat++;
      #1;
    end
    btrace[lat] = busy;
    res = result;
    clk_en = 1'b1;
    start = 1'b0;
  endtask

  initial begin
    logic [20:0]  r;
    logic [20:0]  er;
    int           l;
    int           el;
    int           cyc;
    logic         seen;
    logic [127:0] bt;
    logic [31:0]  x;

    n_cmp  = 0;
    n_err  = 0;
    aclr   = 1'b0;
    clk_en = 1'b1;
    start  = 1'b0;
    dataa  = 32'd0;

    tbl[0]  = '{32'h43000000, 21'h000000, 7};   // 128.0
    tbl[1]  = '{32'h43400000, 21'h080000, 7};   // 192.0
    tbl[2]  = '{32'h3F800000, 21'h102000, 6};   // 1.0
    tbl[3]  = '{32'h00000000, 21'h100000, 2};   // +0
    tbl[4]  = '{32'hC0A00000, 21'h100000, 2};   // -5.0
    tbl[5]  = '{32'h43960000, 21'h0FFFFF, 2};   // 300.0
    tbl[6]  = '{32'h7F800000, 21'h0FFFFF, 2};   // +Inf
    tbl[7]  = '{32'h7FC00000, 21'h000000, 2};   // NaN
    tbl[8]  = '{32'h41000000, 21'h110000, 3};   // 8.0, e = 130, no shift
    tbl[9]  = '{32'h35000000, 21'h100000, 27};  // 2^-21, e = 106
    tbl[10] = '{32'h34800000, 21'h100000, 2};   // 2^-22, e = 105
    tbl[11] = '{32'h43800000, 21'h0FFFFF, 2};   // 256.0, e = 135
    tbl[12] = '{32'h437FFFFF, 21'h0FFFFF, 7};   // largest value below 256
    tbl[13] = '{32'h80000000, 21'h100000, 2};   // -0

    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", {41'd0, result, done, busy}, 64'd0);
    @(negedge clock);
    aclr = 1'b1;

    // Directed table.
    for (int i = 0; i < 14; i++) begin
      do_op(tbl[i].x, 0, 0, r, l, bt);
      check($sformatf("tbl%0d_result", i), 64'(r), 64'(tbl[i].res));
      check($sformatf("tbl%0d_latency", i), 64'(l), 64'(tbl[i].lat));
    end

    // busy profile for 128.0: high in cycles 1..6, low at 7 with done.
    do_op(32'h43000000, 0, 0, r, l, bt);
    check("busy_trace_128", 64'(bt[7:1]), 64'h3F);

    // start pulsed during ALIGN with different data is ignored.
    do_op(32'h43000000, 0, 3, r, l, bt);
    check("ignore_start_result", 64'(r), 64'h000000);
    check("ignore_start_latency", 64'(l), 64'd7);

    // clk_en low for 5 cycles mid-ALIGN stretches latency by 5.
    do_op(32'h43000000, 3, 0, r, l, bt);
    check("stall_result", 64'(r), 64'h000000);
    check("stall_latency", 64'(l), 64'd12);

    // Back-to-back: start held high through DONE.
    @(negedge clock);
    start = 1'b1;
    dataa = 32'h43400000;
    @(posedge clock);
    cyc = 1;
    #1;
    while (done !== 1'b1 && cyc < 60) begin
      if (cyc == 3) dataa = 32'h3F800000;
      @(posedge clock);
      cyc++;
      #1;
    end
    check("b2b_first_latency", 64'(cyc), 64'd7);
    check("b2b_first_result", 64'(result), 64'h080000);
    @(posedge clock);
    #1;
    check("b2b_accept_no_gap", {62'd0, done, busy}, 64'd1);
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 60) begin
      @(posedge clock);
      cyc++;
      #1;
    end
    check("b2b_second_latency", 64'(cyc), 64'd6);
    check("b2b_second_result", 64'(result), 64'h102000);

    // aclr mid-ALIGN: outputs clear at once, no done afterwards.
    do_op(32'h43400000, 0, 0, r, l, bt);
    @(negedge clock);
    start = 1'b1;
    dataa = 32'h43000000;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2;
    check("aclr_busy_before", 64'(busy), 64'd1);
    aclr = 1'b0;
    #1;
    check("aclr_outputs_cleared", {41'd0, result, done, busy}, 64'd0);
    @(negedge clock);
    aclr = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    check("aclr_idle_waits", 64'(seen), 64'd0);
    do_op(32'h3F800000, 0, 0, r, l, bt);
    check("aclr_recover_result", 64'(r), 64'h102000);
    check("aclr_recover_latency", 64'(l), 64'd6);

    // Exponent sweep with random mantissas.
    for (int e = 106; e <= 134; e++) begin
      for (int k = 0; k < 3; k++) begin
        x = {1'b0, 8'(e), 23'($urandom)};
        model(x, er, el);
        do_op(x, 0, 0, r, l, bt);
        check($sformatf("sweep_%08h_result", x), 64'(r), 64'(er));
        check($sformatf("sweep_%08h_latency", x), 64'(l), 64'(el));
      end
    end

    // Fully random operands, specials included.
    for (int k = 0; k < 20; k++) begin
      x = $urandom;
      model(x, er, el);
      do_op(x, 0, 0, r, l, bt);
      check($sformatf("rand_%08h_result", x), 64'(r), 64'(er));
      check($sformatf("rand_%08h_latency", x), 64'(l), 64'(el));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_subdiv_to_fixed.md
# fp_subdiv_to_fixed

Multi-cycle front-end stage that converts an IEEE-754 single-precision operand x into the CORDIC angle z = (x − 128)/128. The result is signed 21-bit Q1.20 fixed point: 1 sign bit, 20 fractional bits, one LSB = 2^-20. It sits directly upstream of the unrolled CORDIC cosine core and drives that core's fixed-point angle input. Its `done` pulse is the core's `start` strobe. The alignment shifter is iterative, one bit per cycle, to keep area small.

## Interface
- No parameters (formats fixed: FP32 in, Q1.20 out).
- `clock` in 1: sole clock, rising edge.
- `aclr` in 1: asynchronous, active-low reset.
- `clk_en` in 1: when low, all state, counters and outputs hold.
- `start` in 1: request; sampled only in IDLE or DONE with `clk_en` high.
- `dataa` in 32: FP32 operand x, captured on the accepting edge.
- `result` out 21: signed Q1.20 z, held until the next result is written.
- `done` out 1: high for exactly the cycle(s) spent in DONE.
- `busy` out 1: high in UNPACK, ALIGN, SUB.

## Operation
States are IDLE, UNPACK, ALIGN, SUB and DONE. Reset state is IDLE with `result` = 0, `done` = 0, `busy` = 0, and internal registers cleared.

- **IDLE / DONE + start:** latch `dataa` and go to UNPACK. In DONE without `start`, go to IDLE. In IDLE without `start`, stay.
- **UNPACK:** decode sign s, exponent e and mantissa; M = {1, frac}, 24 bits. Special cases are checked in this priority order; each writes `result` and goes straight to DONE:
  - NaN (e = 255, frac ≠ 0): `result` = 0x000000.
  - s = 1, or e = 0 (zero or denormal, including −0): `result` = 0x100000 (−1.0).
  - e ≥ 135 (x ≥ 256, including +Inf): `result` = 0x0FFFFF (saturated max).
  - e < 106 (x < 2^-21): `result` = 0x100000.
- **UNPACK, normal case:**
  - Load the 29-bit unsigned accumulator A = M. A is Q8.20; its target value is x·2^20, i.e. M shifted by e − 130.
  - Load count n = |e − 130| (0..24) and direction: left if e > 130, right if e < 130.
  - Go to ALIGN if n > 0, otherwise go to SUB.
- **ALIGN:**
  - Each enabled cycle, shift A one bit in the set direction; right shifts truncate.
  - Decrement n, and go to SUB after the last shift.
  - Left shifts are at most 4, so A ≤ 2^28 − 2^4 and never overflows.
- **SUB:**
  - D = A − 2^27, computed as a signed 30-bit value.
  - `result` = D >>> 7, arithmetic shift, which truncates toward −∞.
  - Go to DONE. The value is always in [0x100000, 0x0FFFFF].
- `start` in UNPACK, ALIGN or SUB is ignored; it is neither queued nor allowed to corrupt the in-flight operation.

## Timing
- Latency is counted from the accepting edge to the first cycle `done` is high, counting enabled cycles only.
  - Special cases: 2.
  - Normal case: n + 3. Minimum 3 (e = 130); maximum 27 (e = 106).
- `result` changes only on the edge that enters DONE. It is stable and valid while `done` is high and afterwards.
- Back-to-back operation: `start` held high in DONE starts the next operation with no idle cycle.
- `clk_en` low freezes the FSM mid-ALIGN; the count resumes unchanged.
- `aclr` asserted in any state immediately forces IDLE, `result` = 0, `done` = 0, `busy` = 0. The in-flight operation is lost and no `done` is produced for it.

## Test plan
- x = 128.0 (0x43000000), e = 134, n = 4 → `done` 7 cycles after the accepting edge, `result` = 0x000000; `busy` high for cycles 1–6.
- x = 192.0 (0x43400000) → 0x080000. x = 1.0 (0x3F800000), e = 127, right shift 3 → 0x102000 after 6 cycles.
- Specials, each with `done` at 2 cycles:
  - 0x00000000 → 0x100000
  - −5.0 (0xC0A00000) → 0x100000
  - 300.0 (0x43960000) → 0x0FFFFF
  - +Inf (0x7F800000) → 0x0FFFFF
  - NaN (0x7FC00000) → 0x000000
- `start` pulsed again during ALIGN of x = 128.0 with a different `dataa` → ignored; `result` = 0x000000 at cycle 7. `start` held in DONE → second operation accepted with no gap.
- `clk_en` low for 5 cycles mid-ALIGN → latency stretches by exactly 5 and the result is unchanged. `aclr` pulled low mid-ALIGN → outputs 0 immediately; after release, IDLE waits for `start`.
- Exponent sweep e = 106..134, with random mantissa and s = 0, against a software model of ⌊(x·2^20 − 2^27)/128⌋ using the truncated x·2^20: bit-exact `result` and latency n + 3.
